// File: rtl/present_serial_core_pkg.sv
// Shared definitions for the nibble-serial PRESENT-80 core.
//   core_state_t  : controller state encoding
//   PRESENT_ROUNDS, KEY_W, BLK_W : cipher dimensions
//   p_layer()     : PRESENT bit permutation (pure wiring once elaborated)
package present_serial_core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SBOX   = 2'd1,
    ST_PLAYER = 2'd2,
    ST_FINAL  = 2'd3
  } core_state_t;

  localparam int PRESENT_ROUNDS = 31;
  localparam int KEY_W          = 80;
  localparam int BLK_W          = 64;

  // Bit j moves to (16*j) mod 63; bit 63 stays in place.
  function automatic logic [63:0] p_layer(input logic [63:0] din);
    logic [63:0] dout;
    dout = '0;
    for (int j = 0; j < 63; j++) begin
      dout[6'((16 * j) % 63)] = din[6'(j)];
    end
    dout[63] = din[63];
    return dout;
  endfunction

endpackage

// File: rtl/present_serial_core_s_box.sv
// PRESENT 4-bit substitution box, purely combinational.
//   din  : 4-bit input nibble
//   dout : substituted nibble
module s_box (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = 4'h0;
    case (din)
      4'h0: dout = 4'hC;
      4'h1: dout = 4'h5;
      4'h2: dout = 4'h6;
      4'h3: dout = 4'hB;
      4'h4: dout = 4'h9;
      4'h5: dout = 4'h0;
      4'h6: dout = 4'hA;
      4'h7: dout = 4'hD;
      4'h8: dout = 4'h3;
      4'h9: dout = 4'hE;
      4'hA: dout = 4'hF;
      4'hB: dout = 4'h8;
      4'hC: dout = 4'h4;
      4'hD: dout = 4'h7;
      4'hE: dout = 4'h1;
      4'hF: dout = 4'h2;
      default: dout = 4'h0;
    endcase
  end

endmodule

// File: rtl/present_serial_core.sv
// Nibble-serial PRESENT-80 encryption core.
//   Clk_ik        : core clock
//   Reset_irn     : synchronous reset, active low
//   Start_i       : start request, honoured only in IDLE
//   Plaintext_ib  : 64-bit plaintext, captured on accepted start
//   Key_ib        : 80-bit key, captured on accepted start
//   Ciphertext_ob : cipher state register; valid with Done_o, held until next start
//   Busy_o        : high while an encryption is in progress
//   Done_o        : one-cycle result-valid pulse
//
// state  | meaning
// IDLE   | waiting for Start_i
// SBOX   | addRoundKey + S-box on one state nibble per cycle (16 cycles)
// PLAYER | bit permutation and key schedule update (1 cycle)
// FINAL  | final key whitening, pulse Done_o (1 cycle)
module present_serial_core
  import present_serial_core_pkg::*;
#(
  parameter int ROUNDS = PRESENT_ROUNDS
) (
  input  logic        Clk_ik,
  input  logic        Reset_irn,
  input  logic        Start_i,
  input  logic [63:0] Plaintext_ib,
  input  logic [79:0] Key_ib,
  output logic [63:0] Ciphertext_ob,
  output logic        Busy_o,
  output logic        Done_o
);

  core_state_t fsm_q, fsm_d;
  logic [63:0] state_q, state_d;
  logic [79:0] key_q, key_d;
  logic [3:0]  nib_q, nib_d;
  logic [4:0]  rnd_q, rnd_d;
  logic        done_q, done_d;

  logic [63:0] round_key;
  logic [3:0]  sb_state_in, sb_state_out;
  logic [79:0] key_rot, key_upd;
  logic [3:0]  sb_key_out;

  assign round_key   = key_q[79:16];
  assign sb_state_in = state_q[{nib_q, 2'b00} +: 4] ^ round_key[{nib_q, 2'b00} +: 4];

  // Key schedule: rotate left by 61, S-box top nibble, mix round counter.
  assign key_rot = {key_q[18:0], key_q[79:19]};
  assign key_upd = {sb_key_out, key_rot[75:20], key_rot[19:15] ^ rnd_q, key_rot[14:0]};

  s_box u_sbox_state (.din(sb_state_in),   .dout(sb_state_out));
  s_box u_sbox_key   (.din(key_rot[79:76]), .dout(sb_key_out));

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    nib_d   = nib_q;
    rnd_d   = rnd_q;
    done_d  = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        if (Start_i) begin
          state_d = Plaintext_ib;
          key_d   = Key_ib;
          nib_d   = 4'd0;
          rnd_d   = 5'd1;
          fsm_d   = ST_SBOX;
        end
      end
      ST_SBOX: begin
        state_d[{nib_q, 2'b00} +: 4] = sb_state_out;
        nib_d = nib_q + 4'd1;
        if (nib_q == 4'd15) fsm_d = ST_PLAYER;
      end
      ST_PLAYER: begin
        state_d = p_layer(state_q);
        key_d   = key_upd;
        if (rnd_q == 5'(ROUNDS)) begin
          fsm_d = ST_FINAL;
        end else begin
          rnd_d = rnd_q + 5'd1;
          fsm_d = ST_SBOX;
        end
      end
      ST_FINAL: begin
        state_d = state_q ^ round_key;
        done_d  = 1'b1;
        fsm_d   = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk_ik) begin
    if (!Reset_irn) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
      key_q   <= '0;
      nib_q   <= 4'd0;
      rnd_q   <= 5'd1;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      nib_q   <= nib_d;
      rnd_q   <= rnd_d;
      done_q  <= done_d;
    end
  end

  assign Ciphertext_ob = state_q;
  assign Busy_o        = (fsm_q != ST_IDLE);
  assign Done_o        = done_q;

endmodule

// File: tb/tb_present_serial_core.sv
// Directed self-checking bench for present_serial_core using the published
// PRESENT-80 test vectors.
module tb_present_serial_core;

  localparam logic [63:0] PT_FF = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [79:0] K_FF  = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] CT_V1 = 64'h5579C1387B228445;
  localparam logic [63:0] CT_V2 = 64'hE72C46C0F5945049;
  localparam logic [63:0] CT_V3 = 64'hA112FFC72F68417B;
  localparam logic [63:0] CT_V4 = 64'h3333DCD3213210D2;
  localparam int LAT = 528;
  localparam int BUDGET = 700;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] pt = '0;
  logic [79:0] key = '0;
  logic [63:0] ct;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  present_serial_core dut (
    .Clk_ik       (clk),
    .Reset_irn    (rst_n),
    .Start_i      (start),
    .Plaintext_ib (pt),
    .Key_ib       (key),
    .Ciphertext_ob(ct),
    .Busy_o       (busy),
    .Done_o       (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One encryption: start, optional ignored start pulses at edges E0+i, then
  // latency / result / busy-length / hold checks.
  task automatic run_op(input string tag, input logic [63:0] p, input logic [79:0] k,
                        input logic [63:0] exp, input int i0, input int i1, input int i2);
    int cyc;
    int busy_cnt;
    int extra_done;
    pt = p; key = k; start = 1'b1;
    tick();
    start = 1'b0;
    pt = ~p; key = ~k;
    chk({tag, " busy_on_accept"}, 64'(busy), 64'd1);
    cyc = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && cyc < BUDGET) begin
      start = (cyc + 1 == i0) || (cyc + 1 == i1) || (cyc + 1 == i2);
      tick();
      cyc++;
      if (busy) busy_cnt++;
    end
    start = 1'b0;
    chk({tag, " latency"}, 64'(cyc), 64'(LAT));
    chk({tag, " ciphertext"}, ct, exp);
    chk({tag, " busy_cycles"}, 64'(busy_cnt), 64'(LAT));
    extra_done = 0;
    repeat (40) begin
      tick();
      if (done) extra_done++;
    end
    chk({tag, " single_done"}, 64'(extra_done), 64'd0);
    chk({tag, " ct_held"}, ct, exp);
    chk({tag, " idle_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < BUDGET) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    int done_seen;

    // reset state
    rst_n = 1'b0;
    repeat (3) tick();
    chk("reset ct", ct, 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    run_op("v1", 64'd0, 80'd0, CT_V1, -1, -1, -1);
    run_op("v2", 64'd0, K_FF, CT_V2, -1, -1, -1);
    run_op("v3", PT_FF, 80'd0, CT_V3, -1, -1, -1);
    run_op("v4_ign", PT_FF, K_FF, CT_V4, 5, 200, 527);

    // reset in the middle of an operation
    pt = 64'd0; key = 80'd0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (299) tick();
    chk("midrst busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst ct", ct, 64'd0);
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst done", 64'(done), 64'd0);
    done_seen = 0;
    repeat (300) begin
      tick();
      if (done || busy) done_seen++;
    end
    chk("midrst no_done", 64'(done_seen), 64'd0);
    run_op("v1_after_rst", 64'd0, 80'd0, CT_V1, -1, -1, -1);

    // back-to-back with Start_i held high
    pt = 64'd0; key = K_FF; start = 1'b1;
    tick();
    wait_done(cyc);
    chk("b2b1 latency", 64'(cyc), 64'(LAT));
    chk("b2b1 ct", ct, CT_V2);
    pt = PT_FF; key = 80'd0;
    tick();
    chk("b2b2 done_drop", 64'(done), 64'd0);
    chk("b2b2 busy", 64'(busy), 64'd1);
    wait_done(cyc);
    chk("b2b2 period", 64'(cyc + 1), 64'(LAT + 1));
    chk("b2b2 ct", ct, CT_V3);
    pt = PT_FF; key = K_FF;
    tick();
    chk("b2b3 done_drop", 64'(done), 64'd0);
    wait_done(cyc);
    chk("b2b3 period", 64'(cyc + 1), 64'(LAT + 1));
    chk("b2b3 ct", ct, CT_V4);
    start = 1'b0;
    repeat (10) tick();
    chk("b2b3 ct_held", ct, CT_V4);
    chk("b2b3 idle", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
